// File: rtl/spi_mstr_mss_if.sv
// Bus bundle for the multi-slave SPI master: host handshake, serial lines and status.
interface spi_mstr_mss_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_SS   = 5,
    parameter int unsigned SS_W   = 3
);
    logic              wrt;
    logic [SS_W-1:0]   ss;
    logic [DATA_W-1:0] cmd;
    logic              MISO;
    logic              SCLK;
    logic              MOSI;
    logic [N_SS-1:0]   SS_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rd_data;

    modport master (
        input  wrt, ss, cmd, MISO,
        output SCLK, MOSI, SS_n, busy, done, err, rd_data
    );

    modport slave (
        output wrt, ss, cmd, MISO,
        input  SCLK, MOSI, SS_n, busy, done, err, rd_data
    );
endinterface

// File: rtl/spi_mstr_mss.sv
// SPI master (CPHA=0) with built-in slave-select decode; every output is a flop.
module spi_mstr_mss #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_SS     = 5,
    parameter int unsigned SS_W     = 3,
    parameter int unsigned SCLK_DIV = 16,
    parameter bit          CPOL     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_mstr_mss_if.master  bus
);
    localparam int unsigned BCW = $clog2(DATA_W + 1);
    localparam int unsigned DCW = $clog2(SCLK_DIV);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
    localparam logic [DCW-1:0] HALF_M1  = DCW'(SCLK_DIV / 2 - 1);
    localparam logic [DCW-1:0] DIV_M1   = DCW'(SCLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

    state_t            state_q, state_d;
    logic [DCW-1:0]    div_q, div_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [N_SS-1:0]   ss_n_q, ss_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            ss_n_q  <= '1;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        ss_n_d  = ss_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.wrt) begin
                    if (32'(bus.ss) < N_SS) begin
                        // MSB goes straight to MOSI; the rest waits in tx for trailing edges
                        state_d = FRONT;
                        div_d   = '0;
                        bit_d   = '0;
                        tx_d    = {bus.cmd[DATA_W-2:0], 1'b0};
                        rx_d    = '0;
                        mosi_d  = bus.cmd[DATA_W-1];
                        busy_d  = 1'b1;
                        for (int unsigned i = 0; i < N_SS; i++) begin
                            ss_n_d[i] = (32'(bus.ss) != i);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FRONT: begin
                if (div_q == HALF_M1) begin
                    state_d = SHIFT;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == HALF_M1) begin
                    sclk_d = ~CPOL;
                    rx_d   = {rx_q[DATA_W-2:0], bus.MISO};
                    div_d  = div_q + 1'b1;
                end else if (div_q == DIV_M1) begin
                    sclk_d = CPOL;
                    div_d  = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = BACK;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        mosi_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            BACK: begin
                if (div_q == HALF_M1) begin
                    state_d = IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                    ss_n_d  = '1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rd_d    = rx_q;
                    mosi_d  = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = mosi_q;
    assign bus.SS_n    = ss_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_spi_mstr_mss.sv
// Directed bench for spi_mstr_mss: default config with MOSI->MISO loopback, plus an 8-bit CPOL=1 instance.
module tb_spi_mstr_mss;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_mstr_mss_if #(.DATA_W(16), .N_SS(5), .SS_W(3)) bus_a ();
    spi_mstr_mss_if #(.DATA_W(8),  .N_SS(5), .SS_W(3)) bus_b ();

    spi_mstr_mss #(.DATA_W(16), .N_SS(5), .SS_W(3), .SCLK_DIV(16), .CPOL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    spi_mstr_mss #(.DATA_W(8), .N_SS(5), .SS_W(3), .SCLK_DIV(4), .CPOL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    assign bus_a.MISO = bus_a.MOSI;
    assign bus_b.MISO = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int edges, edges_b, two_low, stray, stray_b, done_cnt, err_cnt;
    logic [15:0] mosi_sh;
    logic [4:0]  ever_low;
    logic        sclk_prev, sclkb_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        edges = 0; edges_b = 0; two_low = 0; stray = 0; stray_b = 0;
        done_cnt = 0; err_cnt = 0; mosi_sh = '0; ever_low = '0;
    endtask

    // Advance one cycle, sample at the falling edge, and accumulate bus statistics.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus_a.SCLK && !sclk_prev) begin
            edges++;
            mosi_sh = {mosi_sh[14:0], bus_a.MOSI};
        end
        sclk_prev = bus_a.SCLK;
        if (!bus_b.SCLK && sclkb_prev) edges_b++;
        sclkb_prev = bus_b.SCLK;
        if ($countones(~bus_a.SS_n) > 1) two_low++;
        if (bus_a.SS_n == 5'b11111 && bus_a.SCLK) stray++;
        if (bus_b.SS_n == 5'b11111 && !bus_b.SCLK) stray_b++;
        if (bus_a.done) done_cnt++;
        if (bus_a.err) err_cnt++;
        ever_low |= ~bus_a.SS_n;
    endtask

    task automatic pulse_a(input logic [2:0] idx, input logic [15:0] word);
        bus_a.ss = idx; bus_a.cmd = word; bus_a.wrt = 1'b1;
        cyc = 0;
        step();
        bus_a.wrt = 1'b0;
    endtask

    task automatic wait_done_a(input int limit);
        while (!bus_a.done && cyc < limit) step();
        check("done_seen_a", bus_a.done, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.wrt = 1'b0; bus_a.ss = '0; bus_a.cmd = '0;
        bus_b.wrt = 1'b0; bus_b.ss = '0; bus_b.cmd = '0;
        sclk_prev = 1'b0; sclkb_prev = 1'b1;
        clear_stats();
        step(); step(); step();
        check("rst_ss_n",  bus_a.SS_n, 5'b11111);
        check("rst_sclk",  bus_a.SCLK, 0);
        check("rst_mosi",  bus_a.MOSI, 0);
        check("rst_busy",  bus_a.busy, 0);
        check("rst_done",  bus_a.done, 0);
        check("rst_err",   bus_a.err, 0);
        check("rst_rd",    bus_a.rd_data, 16'h0000);
        check("rst_sclk_b", bus_b.SCLK, 1);
        rst_n = 1'b1;
        step(); step();

        // Loopback transfer to ss=4
        clear_stats();
        pulse_a(3'd4, 16'hA5C3);
        check("c1_ss_n", bus_a.SS_n, 5'b01111);
        check("c1_busy", bus_a.busy, 1);
        check("c1_mosi", bus_a.MOSI, 1);
        wait_done_a(400);
        check("lb_done_cyc", cyc, 273);
        check("lb_rd",       bus_a.rd_data, 16'hA5C3);
        check("lb_busy",     bus_a.busy, 0);
        check("lb_ss_n",     bus_a.SS_n, 5'b11111);
        check("lb_mosi0",    bus_a.MOSI, 0);
        check("lb_edges",    edges, 16);
        check("lb_mosi_seq", mosi_sh, 16'hA5C3);
        check("lb_stray",    stray, 0);
        step();
        check("lb_done_pulse", bus_a.done, 0);

        // Out-of-range selects
        pulse_a(3'd5, 16'hFFFF);
        check("e5_err",  bus_a.err, 1);
        check("e5_ss_n", bus_a.SS_n, 5'b11111);
        check("e5_sclk", bus_a.SCLK, 0);
        check("e5_mosi", bus_a.MOSI, 0);
        check("e5_busy", bus_a.busy, 0);
        step();
        check("e5_err_pulse", bus_a.err, 0);
        pulse_a(3'd7, 16'hFFFF);
        check("e7_err",  bus_a.err, 1);
        check("e7_ss_n", bus_a.SS_n, 5'b11111);
        check("e7_busy", bus_a.busy, 0);
        step(); step();

        // wrt while busy is ignored
        clear_stats();
        pulse_a(3'd2, 16'h1234);
        while (cyc < 39) step();
        bus_a.ss = 3'd0; bus_a.cmd = 16'hFFFF; bus_a.wrt = 1'b1;
        step();
        bus_a.wrt = 1'b0;
        wait_done_a(400);
        check("ig_done_cyc", cyc, 273);
        check("ig_rd",       bus_a.rd_data, 16'h1234);
        repeat (20) step();
        check("ig_ever_low", ever_low, 5'b00100);
        check("ig_done_cnt", done_cnt, 1);
        check("ig_err_cnt",  err_cnt, 0);

        // Back-to-back: ss=3 then ss=1 issued in the done cycle
        clear_stats();
        pulse_a(3'd3, 16'h3C5A);
        wait_done_a(400);
        check("bb1_rd",   bus_a.rd_data, 16'h3C5A);
        check("bb1_ss_n", bus_a.SS_n, 5'b11111);
        pulse_a(3'd1, 16'hC001);
        check("bb2_ss_n", bus_a.SS_n, 5'b11101);
        wait_done_a(400);
        check("bb2_done_cyc", cyc, 273);
        check("bb2_rd",       bus_a.rd_data, 16'hC001);
        check("bb_two_low",   two_low, 0);
        check("bb_ever_low",  ever_low, 5'b01010);
        check("bb_done_cnt",  done_cnt, 2);

        // 8-bit, SCLK_DIV=4, CPOL=1 instance with MISO tied high
        clear_stats();
        bus_b.ss = 3'd0; bus_b.cmd = 8'h5A; bus_b.wrt = 1'b1;
        cyc = 0;
        step();
        bus_b.wrt = 1'b0;
        check("b_c1_ss_n", bus_b.SS_n, 5'b11110);
        check("b_c1_sclk", bus_b.SCLK, 1);
        check("b_c1_mosi", bus_b.MOSI, 0);
        while (!bus_b.done && cyc < 100) step();
        check("b_done_seen", bus_b.done, 1);
        check("b_done_cyc",  cyc, 37);
        check("b_rd",        bus_b.rd_data, 8'hFF);
        check("b_edges",     edges_b, 8);
        check("b_stray",     stray_b, 0);
        check("b_sclk_idle", bus_b.SCLK, 1);
        step();

        // Asynchronous reset during bit 5 (SCLK high half)
        clear_stats();
        pulse_a(3'd4, 16'hFFFF);
        while (cyc < 100) step();
        check("mr_pre_sclk", bus_a.SCLK, 1);
        check("mr_pre_ss_n", bus_a.SS_n, 5'b01111);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_ss_n", bus_a.SS_n, 5'b11111);
        check("mr_sclk", bus_a.SCLK, 0);
        check("mr_busy", bus_a.busy, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (300) step();
        check("mr_no_done", done_cnt, 0);
        check("mr_idle_ss", bus_a.SS_n, 5'b11111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
